// File: rtl/conversor_bcd.sv
// conversor_bcd: sequential binary-to-BCD converter (shift-and-add-3, one
// input bit per clock). Produces DIGITS registered BCD digit codes for the
// seven-segment decoders, an overflow flag and a one-cycle done pulse.
// Code 4'hF is the decoders' blank code; on overflow every digit is blanked.
// Optional feature: define CONVERSOR_BCD_BLANK_ZEROS_EN to replace leading
// zero digits (all but digit 0) with the blank code.
module conversor_bcd #(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [WIDTH-1:0]      valor,
  output logic                  ocupado,
  output logic                  pronto,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  estouro
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic {
    OCIOSO  = 1'b0,
    DESLOCA = 1'b1
  } estado_t;

  // Add 3 to every digit that is 5 or more, so the following left shift
  // carries correctly into the next decimal digit.
  function automatic logic [BW-1:0] soma3(input logic [BW-1:0] v);
    logic [BW-1:0] r;
    r = v;
    for (int i = 0; i < DIGITS; i++) begin
      if (v[4*i +: 4] >= 4'd5) r[4*i +: 4] = v[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

  // Display formatting of a valid (non-overflowed) result.
  function automatic logic [BW-1:0] formata(input logic [BW-1:0] v);
    logic [BW-1:0] r;
`ifdef CONVERSOR_BCD_BLANK_ZEROS_EN
    logic visto;
    r     = v;
    visto = 1'b0;
    // Walk from the top digit down; digit 0 always stays visible.
    for (int i = DIGITS - 1; i >= 1; i--) begin
      if (v[4*i +: 4] != 4'd0) visto = 1'b1;
      if (!visto) r[4*i +: 4] = 4'hF;
    end
`else
    r = v;
`endif
    return r;
  endfunction

  localparam logic [BW-1:0] BCD_RST   = formata({BW{1'b0}});
  localparam logic [BW-1:0] BCD_BLANK = {DIGITS{4'hF}};

  estado_t          estado, prox_estado;
  logic [WIDTH-1:0] bin;
  logic [BW-1:0]    acc;
  logic [CW-1:0]    cnt;
  logic             sticky;

  logic [BW-1:0]    acc_adj;
  logic [BW-1:0]    acc_prox;
  logic [WIDTH-1:0] bin_prox;
  logic             saida_bit;
  logic             ultimo;
  logic             ovf_final;
  logic [BW-1:0]    resultado;

  // One double-dabble step and the completed result derived from it.
  always_comb begin
    acc_adj                = soma3(acc);
    {saida_bit, acc_prox}  = {acc_adj, bin[WIDTH-1]};
    bin_prox               = bin << 1;
    ultimo                 = (cnt == CW'(1));
    ovf_final              = sticky | saida_bit;
    resultado              = ovf_final ? BCD_BLANK : formata(acc_prox);
  end

  // State register.
  always_ff @(posedge clock) begin
    if (reset) estado <= OCIOSO;
    else       estado <= prox_estado;
  end

  // Next-state logic: start is only looked at while idle.
  always_comb begin
    prox_estado = estado;
    case (estado)
      OCIOSO:  if (start)  prox_estado = DESLOCA;
      DESLOCA: if (ultimo) prox_estado = OCIOSO;
      default: prox_estado = OCIOSO;
    endcase
  end

  // FSM outputs.
  always_comb begin
    ocupado = (estado == DESLOCA);
  end

  // Working registers: capture on accept, shift while converting.
  always_ff @(posedge clock) begin
    if (estado == OCIOSO && start) begin
      bin    <= valor;
      acc    <= '0;
      cnt    <= CW'(WIDTH);
      sticky <= 1'b0;
    end else if (estado == DESLOCA) begin
      bin    <= bin_prox;
      acc    <= acc_prox;
      cnt    <= cnt - CW'(1);
      sticky <= ovf_final;
    end
  end

  // ---- result stage: outputs change only on the completing edge ----
  // Result registers and done pulse.
  always_ff @(posedge clock) begin
    if (reset) begin
      bcd     <= BCD_RST;
      estouro <= 1'b0;
      pronto  <= 1'b0;
    end else begin
      pronto <= (estado == DESLOCA) && ultimo;
      if (estado == DESLOCA && ultimo) begin
        bcd     <= resultado;
        estouro <= ovf_final;
      end
    end
  end

endmodule

// File: tb/tb_conversor_bcd.sv
// Directed bench for conversor_bcd: two instances (5 and 4 digits) driven by
// the same stimulus; expected values are hand-computed constants.
module tb_conversor_bcd;

`ifdef CONVERSOR_BCD_BLANK_ZEROS_EN
  localparam bit BL = 1'b1;
`else
  localparam bit BL = 1'b0;
`endif

  logic        clock;
  logic        reset;
  logic        start;
  logic [15:0] valor;

  logic        ocupado5, pronto5, estouro5;
  logic [19:0] bcd5;
  logic        ocupado4, pronto4, estouro4;
  logic [15:0] bcd4;

  int n_testes = 0;
  int n_falhas = 0;

  conversor_bcd #(.WIDTH(16), .DIGITS(5)) u_dut5 (
    .clock   (clock),
    .reset   (reset),
    .start   (start),
    .valor   (valor),
    .ocupado (ocupado5),
    .pronto  (pronto5),
    .bcd     (bcd5),
    .estouro (estouro5)
  );

  conversor_bcd #(.WIDTH(16), .DIGITS(4)) u_dut4 (
    .clock   (clock),
    .reset   (reset),
    .start   (start),
    .valor   (valor),
    .ocupado (ocupado4),
    .pronto  (pronto4),
    .bcd     (bcd4),
    .estouro (estouro4)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic verifica(input string tag, input logic [31:0] obs,
                          input logic [31:0] esp);
    n_testes++;
    if (obs !== esp) begin
      n_falhas++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, esp);
    end
  endtask

  // Starts and ends at a falling edge. Pulses start for one cycle, then waits
  // (bounded) for pronto5; returns cycles from acceptance and busy cycles.
  task automatic roda(input logic [15:0] v, output int lat, output int ocup);
    valor = v;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    lat   = 0;
    ocup  = 0;
    while (!pronto5 && lat < 40) begin
      if (ocupado5) ocup++;
      @(negedge clock);
      lat++;
    end
  endtask

  int lat, ocup, npr;

  initial begin
    reset = 1'b1;
    start = 1'b0;
    valor = '0;
    repeat (3) @(negedge clock);
    verifica("rst_ocupado", {31'd0, ocupado5}, 32'd0);
    verifica("rst_pronto",  {31'd0, pronto5},  32'd0);
    verifica("rst_estouro", {31'd0, estouro5}, 32'd0);
    verifica("rst_bcd5",    {12'd0, bcd5}, BL ? 32'hFFFF0 : 32'h00000);
    verifica("rst_bcd4",    {16'd0, bcd4}, BL ? 32'hFFF0  : 32'h0000);
    // reset wins over start on the same edge
    start = 1'b1;
    @(negedge clock);
    verifica("rst_prio", {31'd0, ocupado5}, 32'd0);
    start = 1'b0;
    reset = 1'b0;
    @(negedge clock);

    // 1234: latency, busy length, result
    roda(16'd1234, lat, ocup);
    verifica("lat_1234",   lat,  32'd16);
    verifica("ocup_1234",  ocup, 32'd16);
    verifica("bcd5_1234",  {12'd0, bcd5}, BL ? 32'hF1234 : 32'h01234);
    verifica("est5_1234",  {31'd0, estouro5}, 32'd0);
    verifica("pr4_1234",   {31'd0, pronto4}, 32'd1);
    verifica("bcd4_1234",  {16'd0, bcd4}, 32'h1234);
    verifica("ocup_after", {31'd0, ocupado5}, 32'd0);
    @(negedge clock);
    verifica("pronto_1cy", {31'd0, pronto5}, 32'd0);

    // 65535, then 0 requested in the pronto cycle
    roda(16'd65535, lat, ocup);
    verifica("bcd5_65535", {12'd0, bcd5}, 32'h65535);
    verifica("bcd4_65535", {16'd0, bcd4}, 32'hFFFF);
    verifica("est4_65535", {31'd0, estouro4}, 32'd1);
    roda(16'd0, lat, ocup);
    verifica("lat_b2b",    lat, 32'd16);
    verifica("bcd5_0",     {12'd0, bcd5}, BL ? 32'hFFFF0 : 32'h00000);
    verifica("bcd4_0",     {16'd0, bcd4}, BL ? 32'hFFF0  : 32'h0000);
    verifica("est4_0",     {31'd0, estouro4}, 32'd0);
    @(negedge clock);

    roda(16'd42, lat, ocup);
    verifica("bcd5_42",    {12'd0, bcd5}, BL ? 32'hFFF42 : 32'h00042);
    @(negedge clock);

    // 4-digit boundary
    roda(16'd10000, lat, ocup);
    verifica("bcd4_10000", {16'd0, bcd4}, 32'hFFFF);
    verifica("est4_10000", {31'd0, estouro4}, 32'd1);
    verifica("bcd5_10000", {12'd0, bcd5}, 32'h10000);
    @(negedge clock);
    roda(16'd9999, lat, ocup);
    verifica("bcd4_9999",  {16'd0, bcd4}, 32'h9999);
    verifica("est4_9999",  {31'd0, estouro4}, 32'd0);
    verifica("bcd5_9999",  {12'd0, bcd5}, BL ? 32'hF9999 : 32'h09999);
    @(negedge clock);

    // start during conversion is ignored; valor change has no effect
    valor = 16'd7;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (4) @(negedge clock);
    verifica("hold_bcd5",  {12'd0, bcd5}, BL ? 32'hF9999 : 32'h09999);
    valor = 16'd9;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    npr = 0;
    lat = 5;
    for (int k = 0; k < 30; k++) begin
      if (pronto5) begin
        npr++;
        verifica("lat_ign", lat, 32'd16);
      end
      @(negedge clock);
      lat++;
    end
    verifica("npronto_ign", npr, 32'd1);
    verifica("d0_ign",      {28'd0, bcd5[3:0]}, 32'd7);

    // reset in the middle of a conversion
    valor = 16'd1234;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (7) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    verifica("abort_ocup", {31'd0, ocupado5}, 32'd0);
    npr = 0;
    for (int k = 0; k < 20; k++) begin
      if (pronto5 || pronto4) npr++;
      @(negedge clock);
    end
    verifica("abort_pronto", npr, 32'd0);
    verifica("abort_bcd5", {12'd0, bcd5}, BL ? 32'hFFFF0 : 32'h00000);
    verifica("abort_est4", {31'd0, estouro4}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_testes, n_falhas);
    $finish;
  end

endmodule
